cam_frame_sched: RTL and testbench
==================================

// Module: cam_frame_sched
// PURPOSE
//  Ping-pong frame-buffer scheduler between the register block and the camera write DMA.
//  It hands each camera frame to one of two host buffers (cam_addr_1 / cam_addr_2).
//  When a frame completes it raises a per-buffer XDMA user interrupt.
//  It reuses a buffer only after the host returns that buffer's xdma_ack bit; frames arriving with no free buffer are dropped and counted.
// PARAMETERS
//  ADDR_W   32   width of buffer base addresses and wr_addr
//  CNT_W    16   width of the saturating drop counter
// PORTS
//  clk          in   1       clock; all logic on posedge
//  rst          in   1       synchronous, active-high reset
//  cam_en       in   1       capture enable (register bit, level)
//  cam_addr_1   in   ADDR_W  host base address, buffer 0
//  cam_addr_2   in   ADDR_W  host base address, buffer 1
//  frame_sof    in   1       1-cycle start-of-frame pulse from the camera pipeline (clk domain)
//  wr_done      in   1       1-cycle pulse: DMA writer finished the current frame
//  xdma_ack     in   2       1-cycle per-buffer release pulses from the host (bit0=buf0, bit1=buf1)
//  wr_start     out  1       1-cycle pulse: begin writing a frame at wr_addr
//  wr_addr      out  ADDR_W  base address for the current frame; held from wr_start until wr_done
//  wr_busy      out  1       high from the wr_start cycle until the cycle after wr_done
//  usr_irq_req  out  2       per-buffer interrupt request; level, high while that buffer is FULL
//  buf_full     out  2       buffer ownership: 1 = filled, awaiting host ack
//  drop_cnt     out  CNT_W   frames dropped; saturates at all-ones; cleared only by rst
// BEHAVIOUR
//  Reset: state=IDLE; wr_start=0, wr_busy=0, wr_addr=0, buf_full=0, usr_irq_req=0, drop_cnt=0, next_buf=0.
//  FSM states: IDLE, ARMED, WRITE.
//   IDLE : cam_en=1 -> ARMED. frame_sof is ignored and not counted.
//   ARMED: on frame_sof:
//    - next_buf free -> use it.
//    - only the other buffer free -> use the other.
//    - both full -> drop_cnt+1 and stay in ARMED.
//    - on a grant: next cycle wr_start=1, wr_addr=selected cam_addr_x (sampled at the sof cycle), cur_buf=sel -> WRITE.
//    - cam_en=0 (no sof) -> IDLE.
//   WRITE: on wr_done: buf_full[cur_buf]<=1; next_buf<=~cur_buf; wr_busy<=0.
//    - then ARMED if cam_en=1, else IDLE.
//    - frame_sof during WRITE (writer overrun) -> drop_cnt+1; no new grant.
//    - cam_en falling in WRITE does not abort; the frame completes, then -> IDLE.
//  Latency: sof at cycle N -> wr_start and wr_addr valid at N+1; wr_busy high from N+1.
//   wr_done at M -> buf_full/usr_irq_req set at M+1.
//  Ack: xdma_ack[i]=1 with buf_full[i]=1 -> buf_full[i]<=0 and usr_irq_req[i]<=0 next cycle.
//   Ack to a buffer that is not full (including the one being written) is ignored.
//   Both ack bits in one cycle release both buffers.
//  Simultaneous events:
//   - wr_done and frame_sof in the same cycle: the done is processed and the sof counts as a drop.
//     The FSM goes to ARMED; it is not back-to-back granted.
//   - xdma_ack and frame_sof in the same cycle in ARMED: the release is visible to that same sof's grant decision.
//   - wr_done and an ack to the other buffer in the same cycle: both take effect.
//  usr_irq_req == buf_full at all times.
//  cam_addr_x changes take effect at the next grant only; wr_addr is stable during WRITE.
//  drop_cnt saturates: no wrap at 2^CNT_W-1.
//  rst mid-WRITE: immediate return to reset values; a later wr_done with state!=WRITE is ignored.
// TESTING
//  T1 rst, cam_en=1, addr1=0x1000_0000, addr2=0x2000_0000, sof -> wr_start at +1, wr_addr=0x1000_0000.
//     Then wr_done -> buf_full=01, usr_irq_req=01.
//  T2 continue from T1: sof -> wr_addr=0x2000_0000; wr_done -> buf_full=11.
//     Third sof -> drop_cnt=1, no wr_start; xdma_ack=01 then sof -> wr_addr=0x1000_0000.
//  T3 sof while WRITE -> drop_cnt+1, wr_addr unchanged, single wr_start.
//     Also: wr_done and sof in the same cycle -> drop_cnt+1, state ARMED.
//  T4 cam_en=0 during WRITE -> frame completes (buf_full set), state IDLE; later sofs give no wr_start and no drop.
//  T5 xdma_ack=11 with buf_full=10 -> buf_full=00; ack to the buffer being written -> no change.
//     Force drop_cnt to all-ones -> further drops hold at 0xFFFF.
//  T6 rst asserted mid-WRITE, then wr_done pulse -> all outputs at reset values; no buf_full set.

Source files
------------

// File: rtl/cam_frame_sched.sv
// cam_frame_sched
//   Ping-pong frame-buffer scheduler between the register block and the
//   camera write DMA. Each camera frame is handed to one of two host buffers.
//   A buffer is reused only after the host releases it with its xdma_ack bit.
//   Frames that arrive with no free buffer, or while a frame is still being
//   written, are dropped and counted in a saturating counter.
//
// Ports
//   clk          clock, all logic on posedge
//   rst          synchronous, active-high reset
//   cam_en       capture enable (level)
//   cam_addr_1   host base address of buffer 0
//   cam_addr_2   host base address of buffer 1
//   frame_sof    1-cycle start-of-frame pulse
//   wr_done      1-cycle pulse, DMA writer finished the current frame
//   xdma_ack     per-buffer release pulses from the host (bit0=buf0)
//   wr_start     1-cycle pulse, begin writing a frame at wr_addr
//   wr_addr      base address of the current frame, held through the write
//   wr_busy      high from wr_start until the cycle after wr_done
//   usr_irq_req  per-buffer interrupt request, mirrors buf_full
//   buf_full     1 = buffer filled and awaiting host ack
//   drop_cnt     saturating count of dropped frames
module cam_frame_sched #(
    parameter int ADDR_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cam_en,
    input  logic [ADDR_W-1:0] cam_addr_1,
    input  logic [ADDR_W-1:0] cam_addr_2,
    input  logic              frame_sof,
    input  logic              wr_done,
    input  logic [1:0]        xdma_ack,
    output logic              wr_start,
    output logic [ADDR_W-1:0] wr_addr,
    output logic              wr_busy,
    output logic [1:0]        usr_irq_req,
    output logic [1:0]        buf_full,
    output logic [CNT_W-1:0]  drop_cnt
);

    typedef enum logic [1:0] {IDLE, ARMED, WRITE} state_t;

    state_t state;
    logic   next_buf;
    logic   cur_buf;

    // Ownership after this cycle's host releases; a grant decided in the same
    // cycle as an ack already sees the released buffer.
    logic [1:0] full_rel;
    logic [1:0] done_set;
    logic       grant;
    logic       sel;

    assign full_rel = buf_full & ~xdma_ack;
    assign done_set = (state == WRITE && wr_done) ? (2'b01 << cur_buf) : 2'b00;

    // Prefer the buffer after the last one filled, fall back to the other.
    always_comb begin
        grant = 1'b1;
        sel   = next_buf;
        if (full_rel[next_buf]) begin
            if (!full_rel[~next_buf]) begin
                sel = ~next_buf;
            end else begin
                grant = 1'b0;
            end
        end
    end

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            wr_start <= 1'b0;
            wr_busy  <= 1'b0;
            wr_addr  <= '0;
            buf_full <= 2'b00;
            drop_cnt <= '0;
            next_buf <= 1'b0;
            cur_buf  <= 1'b0;
        end else begin
            wr_start <= 1'b0;
            buf_full <= full_rel | done_set;
            case (state)
                IDLE: begin
                    if (cam_en) begin
                        state <= ARMED;
                    end
                end
                ARMED: begin
                    if (frame_sof) begin
                        if (grant) begin
                            wr_start <= 1'b1;
                            wr_busy  <= 1'b1;
                            wr_addr  <= sel ? cam_addr_2 : cam_addr_1;
                            cur_buf  <= sel;
                            state    <= WRITE;
                        end else begin
                            drop_cnt <= sat_inc(drop_cnt);
                        end
                    end else if (!cam_en) begin
                        state <= IDLE;
                    end
                end
                WRITE: begin
                    // A sof here is a writer overrun, even alongside wr_done.
                    if (frame_sof) begin
                        drop_cnt <= sat_inc(drop_cnt);
                    end
                    if (wr_done) begin
                        next_buf <= ~cur_buf;
                        wr_busy  <= 1'b0;
                        state    <= cam_en ? ARMED : IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign usr_irq_req = buf_full;

endmodule

// File: tb/tb_cam_frame_sched.sv
module tb_cam_frame_sched;

    logic        clk = 1'b0;
    logic        rst, cam_en, frame_sof, wr_done;
    logic [31:0] cam_addr_1, cam_addr_2;
    logic [1:0]  xdma_ack;
    logic        wr_start, wr_busy;
    logic [31:0] wr_addr;
    logic [1:0]  usr_irq_req, buf_full;
    logic [15:0] drop_cnt;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    cam_frame_sched #(.ADDR_W(32), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .cam_en(cam_en),
        .cam_addr_1(cam_addr_1), .cam_addr_2(cam_addr_2),
        .frame_sof(frame_sof), .wr_done(wr_done), .xdma_ack(xdma_ack),
        .wr_start(wr_start), .wr_addr(wr_addr), .wr_busy(wr_busy),
        .usr_irq_req(usr_irq_req), .buf_full(buf_full), .drop_cnt(drop_cnt)
    );

    // Behavioural reference: who owns each buffer, whether capture is on,
    // whether a frame is in flight, and which buffer is preferred next.
    bit          m_owned_by_host [2];
    bit          m_capturing;
    bit          m_in_flight;
    int          m_prefer;
    int          m_target;
    bit          m_start;
    logic [31:0] m_addr;
    int          m_drops;

    function automatic void model_step();
        int pick;
        if (rst) begin
            m_owned_by_host[0] = 0; m_owned_by_host[1] = 0;
            m_capturing = 0; m_in_flight = 0; m_prefer = 0; m_target = 0;
            m_start = 0; m_addr = 0; m_drops = 0;
            return;
        end
        for (int b = 0; b < 2; b++) if (xdma_ack[b]) m_owned_by_host[b] = 0;
        m_start = 0;
        if (m_in_flight) begin
            if (frame_sof) m_drops++;
            if (wr_done) begin
                m_owned_by_host[m_target] = 1;
                m_prefer = 1 - m_target;
                m_in_flight = 0;
                m_capturing = cam_en;
            end
        end else if (m_capturing) begin
            if (frame_sof) begin
                if (!m_owned_by_host[m_prefer]) pick = m_prefer;
                else if (!m_owned_by_host[1 - m_prefer]) pick = 1 - m_prefer;
                else pick = -1;
                if (pick < 0) m_drops++;
                else begin
                    m_start = 1; m_in_flight = 1; m_target = pick;
                    m_addr = (pick == 1) ? cam_addr_2 : cam_addr_1;
                end
            end else if (!cam_en) m_capturing = 0;
        end else if (cam_en) m_capturing = 1;
        if (m_drops > 65535) m_drops = 65535;
    endfunction

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic st, input logic busy,
                           input logic [31:0] addr, input logic [1:0] full,
                           input logic [15:0] drop);
        chk({tag, " wr_start"}, 64'(wr_start), 64'(st));
        chk({tag, " wr_busy"}, 64'(wr_busy), 64'(busy));
        chk({tag, " wr_addr"}, 64'(wr_addr), 64'(addr));
        chk({tag, " buf_full"}, 64'(buf_full), 64'(full));
        chk({tag, " usr_irq_req"}, 64'(usr_irq_req), 64'(full));
        chk({tag, " drop_cnt"}, 64'(drop_cnt), 64'(drop));
    endtask

    task automatic drive(input logic r, input logic en, input logic sof,
                         input logic done, input logic [1:0] ack);
        rst = r; cam_en = en; frame_sof = sof; wr_done = done; xdma_ack = ack;
    endtask

    typedef struct {
        logic        rst, en, sof, done;
        logic [1:0]  ack;
        logic        st, busy;
        logic [31:0] addr;
        logic [1:0]  full;
        logic [15:0] drop;
    } vec_t;

    localparam logic [31:0] A1 = 32'h1000_0000;
    localparam logic [31:0] A2 = 32'h2000_0000;

    vec_t tbl [22];
    logic [63:0] got, want;

    initial begin
        //            rst en sof dn ack    st bsy addr full  drop
        tbl[0]  = '{1, 0, 0, 0, 2'b00, 0, 0, 32'h0, 2'b00, 16'd0};
        tbl[1]  = '{0, 1, 0, 0, 2'b00, 0, 0, 32'h0, 2'b00, 16'd0};
        tbl[2]  = '{0, 1, 1, 0, 2'b00, 1, 1, A1,    2'b00, 16'd0};
        tbl[3]  = '{0, 1, 0, 0, 2'b00, 0, 1, A1,    2'b00, 16'd0};
        tbl[4]  = '{0, 1, 0, 1, 2'b00, 0, 0, A1,    2'b01, 16'd0};
        tbl[5]  = '{0, 1, 1, 0, 2'b00, 1, 1, A2,    2'b01, 16'd0};
        tbl[6]  = '{0, 1, 0, 1, 2'b00, 0, 0, A2,    2'b11, 16'd0};
        tbl[7]  = '{0, 1, 1, 0, 2'b00, 0, 0, A2,    2'b11, 16'd1};
        tbl[8]  = '{0, 1, 0, 0, 2'b01, 0, 0, A2,    2'b10, 16'd1};
        tbl[9]  = '{0, 1, 1, 0, 2'b00, 1, 1, A1,    2'b10, 16'd1};
        tbl[10] = '{0, 1, 1, 0, 2'b00, 0, 1, A1,    2'b10, 16'd2};
        tbl[11] = '{0, 1, 1, 1, 2'b00, 0, 0, A1,    2'b11, 16'd3};
        tbl[12] = '{0, 1, 0, 0, 2'b11, 0, 0, A1,    2'b00, 16'd3};
        tbl[13] = '{0, 1, 1, 0, 2'b00, 1, 1, A2,    2'b00, 16'd3};
        tbl[14] = '{0, 1, 0, 0, 2'b10, 0, 1, A2,    2'b00, 16'd3};
        tbl[15] = '{0, 0, 0, 0, 2'b00, 0, 1, A2,    2'b00, 16'd3};
        tbl[16] = '{0, 0, 0, 1, 2'b00, 0, 0, A2,    2'b10, 16'd3};
        tbl[17] = '{0, 0, 1, 0, 2'b00, 0, 0, A2,    2'b10, 16'd3};
        tbl[18] = '{0, 0, 1, 0, 2'b00, 0, 0, A2,    2'b10, 16'd3};
        tbl[19] = '{0, 1, 0, 0, 2'b01, 0, 0, A2,    2'b10, 16'd3};
        tbl[20] = '{0, 1, 1, 0, 2'b00, 1, 1, A1,    2'b10, 16'd3};
        tbl[21] = '{0, 1, 0, 1, 2'b10, 0, 0, A1,    2'b01, 16'd3};

        cam_addr_1 = A1; cam_addr_2 = A2;
        drive(1, 0, 0, 0, 2'b00);
        #1;

        for (int i = 0; i < 22; i++) begin
            drive(tbl[i].rst, tbl[i].en, tbl[i].sof, tbl[i].done, tbl[i].ack);
            tick();
            chk_all($sformatf("vec%0d", i), tbl[i].st, tbl[i].busy, tbl[i].addr,
                    tbl[i].full, tbl[i].drop);
        end

        // Ack and sof together with both buffers full: the release wins the grant.
        drive(0, 1, 1, 0, 2'b00); tick();
        chk_all("ackA grant buf1", 1, 1, A2, 2'b01, 16'd3);
        drive(0, 1, 0, 1, 2'b00); tick();
        chk_all("ackA fill buf1", 0, 0, A2, 2'b11, 16'd3);
        cam_addr_1 = 32'h3000_0000;
        drive(0, 1, 1, 0, 2'b01); tick();
        chk_all("ackA same-cycle grant", 1, 1, 32'h3000_0000, 2'b10, 16'd3);
        cam_addr_1 = A1;
        drive(0, 1, 0, 0, 2'b11); tick();
        chk_all("ack11 while writing buf0", 0, 1, 32'h3000_0000, 2'b00, 16'd3);

        // Reset mid-write, then a stray wr_done.
        drive(1, 1, 0, 0, 2'b00); tick();
        chk_all("rst mid-write", 0, 0, 32'h0, 2'b00, 16'd0);
        drive(0, 1, 0, 1, 2'b00); tick();
        chk_all("stray done after rst", 0, 0, 32'h0, 2'b00, 16'd0);

        // Saturation: fill both buffers (already ARMED), then hold sof high.
        drive(0, 1, 1, 0, 2'b00); tick();
        drive(0, 1, 0, 1, 2'b00); tick();
        drive(0, 1, 1, 0, 2'b00); tick();
        drive(0, 1, 0, 1, 2'b00); tick();
        chk("sat both full", 64'(buf_full), 64'(2'b11));
        drive(0, 1, 1, 0, 2'b00);
        for (int i = 0; i < 65534; i++) tick();
        chk("sat drop_cnt FFFE", 64'(drop_cnt), 64'(16'hFFFE));
        for (int i = 0; i < 6; i++) tick();
        chk("sat drop_cnt FFFF", 64'(drop_cnt), 64'(16'hFFFF));
        drive(0, 1, 0, 0, 2'b00); tick();

        // Randomised run against the reference model.
        drive(1, 0, 0, 0, 2'b00); tick();
        for (int c = 0; c < 3000; c++) begin
            rst       = ($urandom_range(0, 199) == 0);
            cam_en    = ($urandom_range(0, 9) != 0);
            frame_sof = ($urandom_range(0, 3) == 0);
            wr_done   = ($urandom_range(0, 9) < 3);
            xdma_ack  = {($urandom_range(0, 6) == 0), ($urandom_range(0, 6) == 0)};
            if ($urandom_range(0, 19) == 0) cam_addr_1 = $urandom;
            if ($urandom_range(0, 19) == 0) cam_addr_2 = $urandom;
            tick();
            got  = {10'h0, wr_start, wr_busy, wr_addr, buf_full, usr_irq_req, drop_cnt};
            want = {10'h0, m_start, m_in_flight, m_addr,
                    m_owned_by_host[1], m_owned_by_host[0],
                    m_owned_by_host[1], m_owned_by_host[0], 16'(m_drops)};
            chk($sformatf("rand cycle %0d", c), got, want);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
